// File: rtl/nn_host_loader.sv
// Host-side sequencer for the nn core: unpacks a 16-bit word stream into parameter SRAM and X0 writes,
// then runs one inference with a done/timeout watch and returns the result on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready=1
// L1B    | layer-1 biases, one per word
// L1W    | layer-1 weights, two per word (low byte first)
// W1CLR  | zero-fill unused W1 rows, no stream words
// L2B    | layer-2 biases
// L2W    | layer-2 weights
// L3B    | layer-3 biases
// L3W    | layer-3 weights
// X0     | input vector into the core
// START  | one-cycle nn_start, load timeout counter
// WAIT   | waiting for nn_done or timeout
// RESULT | result held until res_ready
module nn_host_loader #(
    parameter int N_IN     = 7,
    parameter int N_H1     = 32,
    parameter int N_H2     = 16,
    parameter int N_OUT    = 4,
    parameter int W1_DEPTH = 256,
    parameter int TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic        cmd_mode,
    output logic        cmd_ready,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        mem_we,
    output logic [2:0]  mem_sel,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        x0_wr_en,
    output logic [2:0]  x0_wr_addr,
    output logic [15:0] x0_wr_data,
    output logic        nn_start,
    input  logic        nn_done,
    input  logic [1:0]  nn_class,
    input  logic [15:0] nn_score,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_class,
    output logic [15:0] res_score,
    output logic [1:0]  res_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [8:0] W1_USED = 9'(N_H1 * N_IN);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_L1B    = 4'd1;
    localparam logic [3:0] S_L1W    = 4'd2;
    localparam logic [3:0] S_W1CLR  = 4'd3;
    localparam logic [3:0] S_L2B    = 4'd4;
    localparam logic [3:0] S_L2W    = 4'd5;
    localparam logic [3:0] S_L3B    = 4'd6;
    localparam logic [3:0] S_L3W    = 4'd7;
    localparam logic [3:0] S_X0     = 4'd8;
    localparam logic [3:0] S_START  = 4'd9;
    localparam logic [3:0] S_WAIT   = 4'd10;
    localparam logic [3:0] S_RESULT = 4'd11;

    logic [3:0]       state_q, state_d;
    logic [8:0]       idx_q, idx_d;
    logic [7:0]       hi_byte_q, hi_byte_d;
    logic             hi_pend_q, hi_pend_d;
    logic             frm_err_q, frm_err_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             s_ready_q, s_ready_d;
    logic             mem_we_q, mem_we_d;
    logic [2:0]       mem_sel_q, mem_sel_d;
    logic [8:0]       mem_addr_q, mem_addr_d;
    logic [15:0]      mem_wdata_q, mem_wdata_d;
    logic             x0_wr_en_q, x0_wr_en_d;
    logic [2:0]       x0_wr_addr_q, x0_wr_addr_d;
    logic [15:0]      x0_wr_data_q, x0_wr_data_d;
    logic             nn_start_q, nn_start_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_class_q, res_class_d;
    logic [15:0]      res_score_q, res_score_d;
    logic [1:0]       res_err_q, res_err_d;

    logic [2:0] cur_sel;
    logic [8:0] cur_last;
    logic [3:0] nxt_st;
    logic [8:0] nxt_idx;
    logic       hs, at_last, advance, abort;

    // Per-state table: target SRAM, index of the final write, and where to go after it.
    always_comb begin
        cur_sel  = 3'd0;
        cur_last = 9'd0;
        nxt_st   = S_IDLE;
        nxt_idx  = 9'd0;
        case (state_q)
            S_L1B:   begin cur_sel = 3'd0; cur_last = 9'(N_H1 - 1);         nxt_st = S_L1W;   end
            S_L1W:   begin cur_sel = 3'd1; cur_last = W1_USED - 9'd1;       nxt_st = S_W1CLR;
                           nxt_idx = W1_USED; end
            S_W1CLR: begin cur_sel = 3'd1; cur_last = 9'(W1_DEPTH - 1);     nxt_st = S_L2B;   end
            S_L2B:   begin cur_sel = 3'd2; cur_last = 9'(N_H2 - 1);         nxt_st = S_L2W;   end
            S_L2W:   begin cur_sel = 3'd3; cur_last = 9'(N_H2 * N_H1 - 1);  nxt_st = S_L3B;   end
            S_L3B:   begin cur_sel = 3'd4; cur_last = 9'(N_OUT - 1);        nxt_st = S_L3W;   end
            S_L3W:   begin cur_sel = 3'd5; cur_last = 9'(N_OUT * N_H2 - 1); nxt_st = S_X0;    end
            S_X0:    begin cur_sel = 3'd0; cur_last = 9'(N_IN - 1);         nxt_st = S_START; end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hi_byte_d    = hi_byte_q;
        hi_pend_d    = hi_pend_q;
        frm_err_d    = frm_err_q;
        tmr_d        = tmr_q;
        mem_we_d     = 1'b0;
        mem_sel_d    = mem_sel_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        x0_wr_en_d   = 1'b0;
        x0_wr_addr_d = x0_wr_addr_q;
        x0_wr_data_d = x0_wr_data_q;
        nn_start_d   = 1'b0;
        res_valid_d  = res_valid_q;
        res_class_d  = res_class_q;
        res_score_d  = res_score_q;
        res_err_d    = res_err_q;
        hs           = s_valid & s_ready_q;
        at_last      = (idx_q == cur_last);
        advance      = 1'b0;
        abort        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    idx_d     = 9'd0;
                    hi_pend_d = 1'b0;
                    frm_err_d = 1'b0;
                    state_d   = cmd_mode ? S_X0 : S_L1B;
                end
            end
            S_L1B, S_L2B, S_L3B: begin
                if (hs) begin
                    if (s_last) begin
                        abort = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_sel_d   = cur_sel;
                        mem_addr_d  = idx_q;
                        mem_wdata_d = s_data;
                        advance     = 1'b1;
                    end
                end
            end
            S_L1W, S_L2W, S_L3W: begin
                if (hi_pend_q) begin
                    mem_we_d    = 1'b1;
                    mem_sel_d   = cur_sel;
                    mem_addr_d  = idx_q;
                    mem_wdata_d = {{8{hi_byte_q[7]}}, hi_byte_q};
                    hi_pend_d   = 1'b0;
                    advance     = 1'b1;
                end else if (hs) begin
                    if (s_last) begin
                        abort = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_sel_d   = cur_sel;
                        mem_addr_d  = idx_q;
                        mem_wdata_d = {{8{s_data[7]}}, s_data[7:0]};
                        hi_byte_d   = s_data[15:8];
                        hi_pend_d   = 1'b1;
                        idx_d       = idx_q + 9'd1;
                    end
                end
            end
            S_W1CLR: begin
                mem_we_d    = 1'b1;
                mem_sel_d   = cur_sel;
                mem_addr_d  = idx_q;
                mem_wdata_d = 16'h0000;
                advance     = 1'b1;
            end
            S_X0: begin
                if (hs) begin
                    if (s_last && !at_last) begin
                        abort = 1'b1;
                    end else begin
                        x0_wr_en_d   = 1'b1;
                        x0_wr_addr_d = idx_q[2:0];
                        x0_wr_data_d = s_data;
                        if (at_last) frm_err_d = ~s_last;
                        advance      = 1'b1;
                    end
                end
            end
            S_START: begin
                nn_start_d = 1'b1;
                tmr_d      = TMR_W'(TIMEOUT - 1);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (nn_done) begin
                    res_valid_d = 1'b1;
                    res_class_d = nn_class;
                    res_score_d = nn_score;
                    res_err_d   = {1'b0, frm_err_q};
                    state_d     = S_RESULT;
                end else if (tmr_q == '0) begin
                    res_valid_d = 1'b1;
                    res_class_d = 2'd0;
                    res_score_d = 16'h0000;
                    res_err_d   = {1'b1, frm_err_q};
                    state_d     = S_RESULT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (at_last) begin
                state_d = nxt_st;
                idx_d   = nxt_idx;
            end else begin
                idx_d = idx_q + 9'd1;
            end
        end

        // Early s_last drops the word and skips the inference entirely.
        if (abort) begin
            state_d     = S_RESULT;
            res_valid_d = 1'b1;
            res_class_d = 2'd0;
            res_score_d = 16'h0000;
            res_err_d   = 2'b01;
        end

        cmd_ready_d = (state_d == S_IDLE);
        s_ready_d   = (state_d inside {S_L1B, S_L1W, S_L2B, S_L2W, S_L3B, S_L3W, S_X0}) && !hi_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            hi_byte_q    <= '0;
            hi_pend_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            tmr_q        <= '0;
            cmd_ready_q  <= 1'b1;
            s_ready_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_sel_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            x0_wr_en_q   <= 1'b0;
            x0_wr_addr_q <= '0;
            x0_wr_data_q <= '0;
            nn_start_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            res_score_q  <= '0;
            res_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hi_byte_q    <= hi_byte_d;
            hi_pend_q    <= hi_pend_d;
            frm_err_q    <= frm_err_d;
            tmr_q        <= tmr_d;
            cmd_ready_q  <= cmd_ready_d;
            s_ready_q    <= s_ready_d;
            mem_we_q     <= mem_we_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            x0_wr_en_q   <= x0_wr_en_d;
            x0_wr_addr_q <= x0_wr_addr_d;
            x0_wr_data_q <= x0_wr_data_d;
            nn_start_q   <= nn_start_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_score_q  <= res_score_d;
            res_err_q    <= res_err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign s_ready    = s_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_sel    = mem_sel_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign x0_wr_en   = x0_wr_en_q;
    assign x0_wr_addr = x0_wr_addr_q;
    assign x0_wr_data = x0_wr_data_q;
    assign nn_start   = nn_start_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_score  = res_score_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_nn_host_loader.sv
// Directed bench for nn_host_loader: expected SRAM/X0 writes and results are queued as stimulus is driven
// and popped when the DUT produces them.
module tb_nn_host_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_mode = 1'b0;
    logic        cmd_ready;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        mem_we;
    logic [2:0]  mem_sel;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        x0_wr_en;
    logic [2:0]  x0_wr_addr;
    logic [15:0] x0_wr_data;
    logic        nn_start;
    logic        nn_done = 1'b0;
    logic [1:0]  nn_class = '0;
    logic [15:0] nn_score = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_class;
    logic [15:0] res_score;
    logic [1:0]  res_err;

    nn_host_loader #(.TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_ready(cmd_ready),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .x0_wr_en(x0_wr_en), .x0_wr_addr(x0_wr_addr), .x0_wr_data(x0_wr_data),
        .nn_start(nn_start), .nn_done(nn_done), .nn_class(nn_class), .nn_score(nn_score),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_score(res_score), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {logic [2:0] sel; logic [8:0] addr; logic [15:0] data;} mw_t;
    typedef struct packed {logic [2:0] addr; logic [15:0] data;} xw_t;
    typedef struct packed {logic [1:0] cls; logic [15:0] score; logic [1:0] err;} rs_t;

    mw_t mem_q[$];
    xw_t x0_q[$];
    rs_t res_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int start_cnt = 0;
    int start_cyc = 0;
    int x0_last_cyc = 0;

    always @(negedge clk) begin : mon
        mw_t me;
        xw_t xe;
        if (rst_n) begin
            if (mem_we) begin
                chk("mem_write_expected", mem_q.size() != 0, 1);
                if (mem_q.size() != 0) begin
                    me = mem_q.pop_front();
                    chk("mem_write", {mem_sel, mem_addr, mem_wdata}, me);
                end
            end
            if (x0_wr_en) begin
                chk("x0_write_expected", x0_q.size() != 0, 1);
                if (x0_q.size() != 0) begin
                    xe = x0_q.pop_front();
                    chk("x0_write", {x0_wr_addr, x0_wr_data}, xe);
                end
                if (x0_wr_addr == 3'd6) x0_last_cyc = cyc;
            end
            if (nn_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
        end
    end

    int  wcount, abort_at, cut_at;
    bit  aborted;
    int  w2_first, w2_last, w2_badwait;

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    task automatic push_res(input logic [1:0] c, input logic [15:0] s, input logic [1:0] e);
        rs_t r;
        r.cls = c; r.score = s; r.err = e;
        res_q.push_back(r);
    endtask

    task automatic send_cmd(input logic m);
        int n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_mode = m;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_mode = 1'b0;
    endtask

    task automatic put_word(input logic [15:0] d, input logic last, output int waits, output int hc);
        s_valid = 1'b1; s_data = d; s_last = last; waits = 0;
        while (!s_ready && waits < 200) begin @(negedge clk); waits++; end
        if (waits >= 200) chk("s_ready_timeout", s_ready, 1);
        hc = cyc;
        @(negedge clk);
    endtask

    task automatic stream(input logic [2:0] sel, input int nw, input bit wt, input bit ramp, input bit w80ff);
        logic [15:0] d;
        bit take;
        int waits, hc;
        for (int i = 0; i < nw; i++) begin
            if (aborted) return;
            if (wcount == cut_at) begin
                aborted = 1; s_valid = 1'b0; s_last = 1'b0;
                return;
            end
            d = ramp ? 16'(i + 1) : (w80ff && i == 0) ? 16'h80FF : 16'($urandom);
            take = (wcount != abort_at);
            if (take) begin
                if (wt) begin
                    mem_q.push_back({sel, 9'(2 * i), sext8(d[7:0])});
                    mem_q.push_back({sel, 9'(2 * i + 1), sext8(d[15:8])});
                end else begin
                    mem_q.push_back({sel, 9'(i), d});
                end
            end
            put_word(d, !take, waits, hc);
            if (!take) aborted = 1;
            wcount++;
            if (sel == 3'd3) begin
                if (i == 0) w2_first = hc;
                if (i == nw - 1) w2_last = hc;
                if (i > 0 && waits != 1) w2_badwait++;
            end
        end
    endtask

    task automatic send_x0(input logic [15:0] base, input bit final_last);
        logic [15:0] d;
        bit take;
        int waits, hc;
        for (int i = 0; i < 7; i++) begin
            if (aborted) return;
            d = base + 16'(i);
            take = (wcount != abort_at);
            if (take) x0_q.push_back({3'(i), d});
            put_word(d, take ? (i == 6 ? final_last : 1'b0) : 1'b1, waits, hc);
            if (!take) aborted = 1;
            wcount++;
        end
    endtask

    task automatic load_mode0(input int ab, input int cut);
        wcount = 0; abort_at = ab; cut_at = cut; aborted = 0; w2_badwait = 0;
        send_cmd(1'b0);
        stream(3'd0, 32, 0, 1, 0);
        stream(3'd1, 112, 1, 0, 1);
        if (!aborted)
            for (int k = 0; k < 32; k++) mem_q.push_back({3'd1, 9'(224 + k), 16'h0000});
        stream(3'd2, 16, 0, 0, 0);
        stream(3'd3, 256, 1, 0, 0);
        stream(3'd4, 4, 0, 0, 0);
        stream(3'd5, 32, 1, 0, 0);
        send_x0(16'h0100, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic load_mode1(input logic [15:0] base, input bit final_last);
        wcount = 0; abort_at = -1; cut_at = -1; aborted = 0;
        send_cmd(1'b1);
        send_x0(base, final_last);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_start(output int c);
        int n = 0;
        while (!nn_start && n < 100) begin @(negedge clk); n++; end
        chk("nn_start_seen", nn_start, 1);
        c = cyc;
    endtask

    task automatic do_done(input logic [1:0] c, input logic [15:0] s);
        repeat (3) @(negedge clk);
        nn_done = 1'b1; nn_class = c; nn_score = s;
        @(negedge clk);
        nn_done = 1'b0; nn_class = '0; nn_score = '0;
    endtask

    task automatic get_result(input int hold, output int c);
        rs_t e = '0;
        int n = 0;
        while (!res_valid && n < 400) begin @(negedge clk); n++; end
        c = cyc;
        chk("res_valid", res_valid, 1);
        chk("res_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) e = res_q.pop_front();
        chk("result", {res_class, res_score, res_err}, e);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("result_hold", {res_valid, res_class, res_score, res_err}, {1'b1, e});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, cs, cr;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_outputs", {s_ready, mem_we, mem_sel, mem_addr, mem_wdata, x0_wr_en, x0_wr_addr,
                              x0_wr_data, nn_start, res_valid, res_class, res_score, res_err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // full load, result held for 20 cycles
        s0 = start_cnt;
        push_res(2'd2, 16'h1234, 2'b00);
        load_mode0(-1, -1);
        wait_start(cs);
        do_done(2'd2, 16'h1234);
        get_result(20, cr);
        chk("m0_single_start", start_cnt - s0, 1);
        chk("m0_mem_drained", mem_q.size(), 0);
        chk("m0_x0_drained", x0_q.size(), 0);
        chk("w2_cycles", w2_last - w2_first + 2, 512);
        chk("w2_throttle", w2_badwait, 0);

        // X0-only inference
        push_res(2'd1, 16'h0777, 2'b00);
        load_mode1(16'h0010, 1'b1);
        wait_start(cs);
        do_done(2'd1, 16'h0777);
        chk("start_after_x0", start_cyc - x0_last_cyc, 1);
        get_result(0, cr);
        chk("m1_x0_drained", x0_q.size(), 0);

        // final word without s_last: framing flag, inference still runs
        push_res(2'd3, 16'h00AB, 2'b01);
        load_mode1(16'h0200, 1'b0);
        wait_start(cs);
        do_done(2'd3, 16'h00AB);
        get_result(0, cr);

        // no done: timeout
        push_res(2'd0, 16'h0000, 2'b10);
        load_mode1(16'h0300, 1'b1);
        wait_start(cs);
        get_result(0, cr);
        chk("timeout_latency", cr - cs, 100);

        // early s_last on word 50
        s0 = start_cnt;
        push_res(2'd0, 16'h0000, 2'b01);
        load_mode0(50, -1);
        get_result(0, cr);
        chk("abort_no_start", start_cnt - s0, 0);
        chk("abort_mem_drained", mem_q.size(), 0);

        // reset in the middle of L2W, then a clean reload
        load_mode0(-1, 170);
        repeat (3) @(negedge clk);
        chk("cut_mem_drained", mem_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_outputs", {s_ready, mem_we, mem_sel, mem_addr, mem_wdata, x0_wr_en, x0_wr_addr,
                               x0_wr_data, nn_start, res_valid, res_class, res_score, res_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s0 = start_cnt;
        push_res(2'd0, 16'hBEEF, 2'b00);
        load_mode0(-1, -1);
        wait_start(cs);
        do_done(2'd0, 16'hBEEF);
        get_result(0, cr);
        chk("reload_single_start", start_cnt - s0, 1);
        chk("reload_mem_drained", mem_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nn_host_loader.md
Name: nn_host_loader

Overview:
- Host-side sequencer for nn_top_csw_7_32_16_4.
- Accepts a command plus a 16-bit word stream carrying the parameter and input image.
- Programs the B1/W1/B2/W2/B3/W3 SRAMs through a single write port. Weights arrive packed two per word and are unpacked and sign-extended 8→16 on the way in.
- Writes X0 through the core's host write port, pulses start, waits for done (with timeout) and returns class/score/error on a valid/ready result port.

Parameters:
- N_IN, 7, input vector length (X0 entries).
- N_H1, 32, layer-1 neurons (B1 entries).
- N_H2, 16, layer-2 neurons (B2 entries).
- N_OUT, 4, output classes (B3 entries).
- W1_DEPTH, 256, physical W1 rows; rows N_H1*N_IN..W1_DEPTH-1 are zero-filled.
- TIMEOUT, 65535, max cycles from start pulse to done.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_mode  in  1  0 = full load (params + X0) then infer; 1 = X0 only then infer
- cmd_ready  out  1  high only in IDLE
- s_valid  in  1  stream word valid
- s_data  in  16  stream word
- s_last  in  1  marks final word of image
- s_ready  out  1  stream accept
- mem_we  out  1  param SRAM write strobe
- mem_sel  out  3  0=B1 1=W1 2=B2 3=W2 4=B3 5=W3
- mem_addr  out  9  SRAM word address
- mem_wdata  out  16  SRAM write data
- x0_wr_en  out  1  core X0 write enable
- x0_wr_addr  out  3  X0 index
- x0_wr_data  out  16  X0 value
- nn_start  out  1  one-cycle start pulse to core
- nn_done  in  1  core done
- nn_class  in  2  core class_out
- nn_score  in  16  core score_max
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_class  out  2  captured class
- res_score  out  16  captured score
- res_err  out  2  bit0 framing error, bit1 timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0 except cmd_ready=1. Reset mid-stream or mid-inference abandons the operation; partially written SRAM contents are left as is.
- All outputs are registered. cmd handshake (cmd_valid & cmd_ready) leaves IDLE: mode 0 → L1B, mode 1 → X0.
- Stream order (mode 0), in words:
  - L1B: 32 words, one bias per word.
  - L1W: 112 words, two weights per word.
  - W1CLR: no words consumed.
  - L2B: 16 words.
  - L2W: 256 words.
  - L3B: 4 words.
  - L3W: 32 words.
  - X0: 7 words.
- Word count per image: 459 (mode 0), 7 (mode 1).
- Bias/X0 states:
  - A handshake at cycle T gives a write at T+1 with data = s_data and addr = running index from 0.
  - s_ready stays high, so one word per cycle.
- Weight states:
  - A handshake at T writes low byte s_data[7:0] sign-extended at T+1, addr a.
  - High byte s_data[15:8] sign-extended is written at T+2, addr a+1.
  - s_ready=0 during the T+1 cycle, so throughput is one word per 2 cycles.
  - Addresses are contiguous: n*fan_in + i.
- W1CLR: s_ready=0. Writes 0 to W1 addr 224..255, one per cycle (32 cycles), then enters L2B.
- X0: x0_wr_addr = 0..6. After the 7th write, state START.
- START: nn_start=1 for exactly one cycle, timeout counter cleared, then WAIT.
- WAIT:
  - nn_done=1 → capture nn_class/nn_score, res_err[1]=0.
  - Counter reaching TIMEOUT first → res_class=0, res_score=0, res_err[1]=1.
  - Either outcome → RESULT.
- RESULT: res_valid=1, fields stable until res_ready. res_valid & res_ready → IDLE, res_valid=0 next cycle.
- Framing errors:
  - s_last=1 on any word before the final expected word: abort immediately to RESULT with res_err[0]=1, no nn_start, class/score 0. The errant word is not written.
  - Final expected word accepted with s_last=0: set res_err[0]=1, still complete the inference normally.
- Ignored inputs: cmd_valid outside IDLE; s_valid in START/WAIT/RESULT/IDLE (s_ready=0). nn_done outside WAIT is ignored.
- Signed arithmetic: sign extension only, no truncation of 16-bit biases/X0.

Test Plan:
- Mode 0 image: bias words 0x0001..0x0020, W1 word 0x80FF → W1[0]=0xFFFF, W1[1]=0xFF80. Check W1[224..255]=0, all 459 words accepted, single nn_start; model nn_done with class 2, score 0x1234 → res 2/0x1234, err 0.
- Mode 1: 7 words 0x0010..0x0016 → x0_wr_addr 0..6 with matching data; no mem_we; nn_start one cycle after the 7th write.
- Weight throttling: s_valid held high through L2W → s_ready toggles 1,0; 256 words take 512 cycles; W2 addr 0..511 strictly increasing.
- Early s_last on word 50 of mode 0 → res_err=01, no nn_start, no write for word 50, cmd_ready=1 after res_ready.
- Done never asserted with TIMEOUT=100 → res_valid exactly 100 cycles after nn_start (±1 registered), res_err=10, score 0.
- rst_n pulsed low mid-L2W → all outputs 0 immediately, cmd_ready=1; a subsequent mode 0 load completes correctly. Separately, hold res_ready low for 20 cycles → result fields stable throughout.
